// File: rtl/stage_memory.sv
// MEM pipeline stage: drives the data-memory bus with a req/ready handshake and registers MEM/WB.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state watchdog that aborts a stuck access.
module stage_memory
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_clear,
    input  logic        mem_reg_write,
    input  logic        mem_mem_write,
    input  logic [1:0]  mem_result_src,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] mem_pc_plus_4,
    input  logic [31:0] mem_imm_ext,
    input  logic [4:0]  mem_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        dmem_timeout,
    output logic        wb_reg_write,
    output logic [1:0]  wb_result_src,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_pc_plus_4,
    output logic [31:0] wb_imm_ext,
    output logic [4:0]  wb_rd
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   access_s;
    logic   is_load_s;
    logic   misaligned_s;
    logic   req_s;
    logic   complete_s;
    logic   timeout_hit_s;
    logic   retire_s;
    logic   misalign_err_r;

    assign access_s     = mem_mem_write | (mem_result_src == 2'b01);
    assign is_load_s    = ~mem_mem_write & (mem_result_src == 2'b01);
    assign misaligned_s = access_s & (mem_alu_result[1:0] != 2'b00);

    // Reset gates the request combinationally so the bus is released without a clock edge.
    assign dmem_req     = reset & req_s;
    assign dmem_we      = mem_mem_write;
    assign dmem_addr    = mem_alu_result;
    assign dmem_wdata   = mem_write_data;
    assign mem_stall    = dmem_req & ~dmem_ready;
    assign complete_s   = dmem_req & dmem_ready;
    assign misalign_err = misalign_err_r;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_r;
    logic       timeout_r;

    assign timeout_hit_s = (state_r == WAIT) & ~dmem_ready &
                           (wait_cnt_r == 8'(TIMEOUT_CYCLES - 1));
    // The held instruction is still in EX/MEM the cycle after an abort; it retires as a bubble.
    assign retire_s      = timeout_r;
    assign dmem_timeout  = timeout_r;

    // Watchdog counter of WAIT cycles for the current access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == IDLE) && (state_next_s == WAIT)) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Timeout pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_hit_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign retire_s      = 1'b0;
    assign dmem_timeout  = 1'b0;
`endif

    // Bus FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bus FSM next state and request.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = access_s & ~misaligned_s & ~retire_s;
                if (req_s && !dmem_ready) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem_ready || timeout_hit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                req_s        = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Misalignment pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err_r <= 1'b0;
        end else begin
            misalign_err_r <= misaligned_s;
        end
    end

    // MEM/WB pipeline register: flush, bubble or capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'b00;
            wb_alu_result <= 32'd0;
            wb_read_data  <= 32'd0;
            wb_pc_plus_4  <= 32'd0;
            wb_imm_ext    <= 32'd0;
            wb_rd         <= 5'd0;
        end else if (wb_clear) begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'b00;
            wb_alu_result <= 32'd0;
            wb_read_data  <= 32'd0;
            wb_pc_plus_4  <= 32'd0;
            wb_imm_ext    <= 32'd0;
            wb_rd         <= 5'd0;
        end else if (mem_stall || misaligned_s || retire_s) begin
            wb_reg_write  <= 1'b0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_result_src <= mem_result_src;
            wb_alu_result <= mem_alu_result;
            wb_pc_plus_4  <= mem_pc_plus_4;
            wb_imm_ext    <= mem_imm_ext;
            wb_rd         <= mem_rd;
            if (complete_s && is_load_s) begin
                wb_read_data <= dmem_rdata;
            end else begin
                wb_read_data <= wb_read_data;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory (default build; MEM_TIMEOUT_EN adds the watchdog scenario).
module tb_stage_memory;

    logic        clk;
    logic        reset;
    logic        wb_clear;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_write_data;
    logic [31:0] mem_pc_plus_4;
    logic [31:0] mem_imm_ext;
    logic [4:0]  mem_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        misalign_err;
    logic        dmem_timeout;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic [31:0] wb_pc_plus_4;
    logic [31:0] wb_imm_ext;
    logic [4:0]  wb_rd;

    int checks   = 0;
    int failures = 0;

    stage_memory dut (
        .clk            (clk),
        .reset          (reset),
        .wb_clear       (wb_clear),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_write  (mem_mem_write),
        .mem_result_src (mem_result_src),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .mem_rd         (mem_rd),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .misalign_err   (misalign_err),
        .dmem_timeout   (dmem_timeout),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext),
        .wb_rd          (wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic rw, input logic mw, input logic [1:0] rs, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [4:0] rd);
        mem_reg_write  = rw;
        mem_mem_write  = mw;
        mem_result_src = rs;
        mem_alu_result = alu;
        mem_write_data = wd;
        mem_pc_plus_4  = pc4;
        mem_imm_ext    = imm;
        mem_rd         = rd;
    endtask

    initial begin
        reset      = 1'b0;
        wb_clear   = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_wb_alu", wb_alu_result, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_timeout", {31'd0, dmem_timeout}, 32'd0);
        reset = 1'b1;

        // zero-wait load
        op(1'b1, 1'b0, 2'b01, 32'h100, 32'd0, 32'h104, 32'd0, 5'd5);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_stall", {31'd0, mem_stall}, 32'd0);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h100);
        tick();
        chk("ld_wb_data", wb_read_data, 32'hDEADBEEF);
        chk("ld_wb_src", {30'd0, wb_result_src}, 32'd1);
        chk("ld_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("ld_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("ld_wb_pc4", wb_pc_plus_4, 32'h104);

        // store with 3 wait cycles
        op(1'b0, 1'b1, 2'b00, 32'h200, 32'h12345678, 32'h204, 32'd0, 5'd0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall", {31'd0, mem_stall}, 32'd1);
            chk("st_req", {31'd0, dmem_req}, 32'd1);
            chk("st_we", {31'd0, dmem_we}, 32'd1);
            chk("st_addr", dmem_addr, 32'h200);
            chk("st_wdata", dmem_wdata, 32'h12345678);
            tick();
            chk("st_bubble_rw", {31'd0, wb_reg_write}, 32'd0);
            chk("st_bubble_rd", {27'd0, wb_rd}, 32'd5);
        end
        dmem_ready = 1'b1;
        #1;
        chk("st_done_stall", {31'd0, mem_stall}, 32'd0);
        chk("st_done_req", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("st_wb_alu", wb_alu_result, 32'h200);
        chk("st_wb_data_hold", wb_read_data, 32'hDEADBEEF);
        chk("st_wb_rw", {31'd0, wb_reg_write}, 32'd0);

        // misaligned load
        op(1'b1, 1'b0, 2'b01, 32'h102, 32'd0, 32'h108, 32'd0, 5'd6);
        dmem_rdata = 32'h11111111;
        #1;
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("mis_wb_alu_hold", wb_alu_result, 32'h200);

        // ALU op, then flush
        op(1'b1, 1'b0, 2'b00, 32'h55, 32'd0, 32'h1004, 32'h77, 5'd7);
        dmem_ready = 1'b0;
        #1;
        chk("alu_req", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("mis_err_pulse_end", {31'd0, misalign_err}, 32'd0);
        chk("alu_wb_alu", wb_alu_result, 32'h55);
        chk("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("alu_wb_rd", {27'd0, wb_rd}, 32'd7);
        chk("alu_wb_imm", wb_imm_ext, 32'h77);
        chk("alu_wb_data_hold", wb_read_data, 32'hDEADBEEF);
        wb_clear = 1'b1;
        tick();
        wb_clear = 1'b0;
        chk("clr_wb_alu", wb_alu_result, 32'd0);
        chk("clr_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("clr_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("clr_wb_data", wb_read_data, 32'd0);
        chk("clr_wb_imm", wb_imm_ext, 32'd0);

        // pc+4 writeback
        op(1'b1, 1'b0, 2'b10, 32'h0, 32'd0, 32'h2008, 32'd0, 5'd3);
        tick();
        chk("pc4_wb_src", {30'd0, wb_result_src}, 32'd2);
        chk("pc4_wb_pc4", wb_pc_plus_4, 32'h2008);
        chk("pc4_wb_rw", {31'd0, wb_reg_write}, 32'd1);

`ifdef MEM_TIMEOUT_EN
        // responder never answers: 1 IDLE + 16 WAIT stall cycles, then abort
        op(1'b1, 1'b0, 2'b01, 32'h300, 32'd0, 32'h304, 32'd0, 5'd9);
        dmem_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("to_stall", {31'd0, mem_stall}, 32'd1);
            chk("to_early", {31'd0, dmem_timeout}, 32'd0);
            tick();
        end
        chk("to_pulse", {31'd0, dmem_timeout}, 32'd1);
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_stall_rel", {31'd0, mem_stall}, 32'd0);
        op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("to_pulse_end", {31'd0, dmem_timeout}, 32'd0);
        chk("to_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("to_wb_pc4_hold", wb_pc_plus_4, 32'h2008);
`else
        // long wait never aborts in the default build
        op(1'b1, 1'b0, 2'b01, 32'h300, 32'd0, 32'h304, 32'd0, 5'd9);
        dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("lw_stall", {31'd0, mem_stall}, 32'd1);
            tick();
        end
        chk("lw_no_timeout", {31'd0, dmem_timeout}, 32'd0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE0001;
        #1;
        chk("lw_done_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("lw_wb_data", wb_read_data, 32'hCAFE0001);
        chk("lw_wb_rd", {27'd0, wb_rd}, 32'd9);
        chk("lw_wb_rw", {31'd0, wb_reg_write}, 32'd1);
`endif

        // asynchronous reset while in WAIT
        op(1'b1, 1'b0, 2'b01, 32'h400, 32'd0, 32'h404, 32'd0, 5'd10);
        dmem_ready = 1'b0;
        tick();
        #1;
        chk("ar_req_before", {31'd0, dmem_req}, 32'd1);
        chk("ar_stall_before", {31'd0, mem_stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("ar_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("ar_stall_drop", {31'd0, mem_stall}, 32'd0);
        chk("ar_wb_pc4", wb_pc_plus_4, 32'd0);
        chk("ar_wb_rd", {27'd0, wb_rd}, 32'd0);
        op(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("ar_idle_req", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("ar_idle_stall", {31'd0, mem_stall}, 32'd0);
        chk("ar_wb_data", wb_read_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
